note_scheduler: RTL and testbench
=================================

# note_scheduler

Chart sequencer for the arrow-drop game. Steps through a note chart ROM one frame per `frame_clk` and launches each note into a free slot of a shared pool of arrow-dropper instances. Collects per-slot hit/miss pulses and keeps score and combo. Sits between the keyboard keycode path, the chart ROM and the dropper pool; the display reads its outputs.

## Interface
- `NUM_SLOTS`, 8: number of dropper instances in the pool.
- `LANE_W`, 2: lane index width (4 lanes).
- `ADDR_W`, 6: chart ROM address width (64 entries).
- `TIME_W`, 12: song-frame counter width.
- `frame_clk` in 1: frame clock; the only clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `keycode`, `keycode_second` in 8 each: USB keycodes. 0x2C = start, 0x01 = restart/abort.
- `chart_addr` out ADDR_W: registered ROM address.
- `chart_time` in TIME_W: launch frame of the entry. Valid one cycle after `chart_addr` changes.
- `chart_lane` in LANE_W: lane of the entry.
- `chart_last` in 1: entry is the final note.
- `slot_busy` in NUM_SLOTS: slot currently holds a falling arrow.
- `slot_hit` in NUM_SLOTS: one-cycle pulse, slot scored.
- `slot_miss` in NUM_SLOTS: one-cycle pulse, slot reached bottom unhit.
- `launch` out NUM_SLOTS: one-hot, one-cycle launch pulse.
- `launch_lane` out LANE_W: lane for the slot in `launch`. Held until the next launch.
- `clear_all` out 1: one-cycle pulse; all slots return to idle.
- `song_frame` out TIME_W: frames elapsed in PLAY.
- `score` out 16: saturating hit count.
- `combo` out 8: current consecutive hits, saturating.
- `max_combo` out 8: best combo this song.
- `game_state` out 3: encoded FSM state.

## Operation
- States: IDLE, LOAD, FETCH, PLAY, DRAIN, DONE.
- IDLE:
  - Holds `chart_addr`=0, `song_frame`=0, `combo`=0.
  - Holds `score`/`max_combo` from the last song.
  - Start key on either keycode input → LOAD. Entering LOAD clears `score` and `max_combo`.
- LOAD: one wait cycle for ROM data at address 0 → PLAY.
- PLAY:
  - `song_frame` increments every cycle and saturates at all-ones.
  - The entry is due when `song_frame >= chart_time`.
  - If an entry is due and any `slot_busy` bit is 0: pulse `launch` on the lowest-index free slot and drive `launch_lane` = `chart_lane`.
  - After that launch: if `chart_last`=1 → DRAIN; otherwise `chart_addr` increments and the FSM goes to FETCH.
  - A due entry with no free slot stays pending. It launches on the first cycle a slot frees; late launches are allowed and no entry is skipped.
- FETCH: one cycle for new ROM data; `song_frame` keeps counting → PLAY.
- DRAIN: `song_frame` keeps counting; `slot_busy`==0 → DONE.
- DONE: all outputs hold; restart key → IDLE.
- Abort: restart key in LOAD, FETCH, PLAY or DRAIN → IDLE, with one `clear_all` pulse in the same cycle the FSM enters IDLE.
- Scoring runs every cycle in every state except IDLE:
  - `score` += popcount(`slot_hit`), saturating at 0xFFFF.
  - If any `slot_miss` bit is set: `combo` ← 0, even when hits arrive in the same cycle.
  - Otherwise `combo` += popcount(`slot_hit`), saturating at 0xFF.
  - `max_combo` ← max(`max_combo`, new `combo`).
- Start and restart on the same cycle: restart wins.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `chart_addr` 0, `launch` 0, `launch_lane` 0, `clear_all` 0, `song_frame` 0, `score` 0, `combo` 0, `max_combo` 0.
- Key → state change: 1 cycle.
- Due condition true → `launch` pulse: 1 cycle later.
- Launch throughput: at most one launch every 2 cycles (PLAY→FETCH→PLAY).
- Hit/miss pulse → `score`/`combo` update: 1 cycle.
- `Reset_n` asserted mid-song: every register returns immediately to its reset value; no `clear_all` pulse (the droppers take the same reset).

## Structure
- `rhythm_pkg` holds:
  - the state enum;
  - `KEY_START`=8'h2C and `KEY_RESTART`=8'h01;
  - the lane typedef.
- Sub-module `slot_alloc`: combinational lowest-index-free priority encoder plus a popcount of hits, parameterised on `NUM_SLOTS`.

## Test plan
- Reset, then keycode=0x2C, ROM {t=5,lane=1,last=0}, all slots free → `launch`=8'b0000_0001 with `launch_lane`=1 on the cycle after `song_frame`=5.
- Entries at t=3 and t=3 → second launch lands in slot 1 two cycles after the first (FETCH gap).
- `slot_busy`=8'hFF when an entry is due; free slot 6 at `song_frame`=20 → `launch`=8'b0100_0000 at frame 21.
- Hits on slots 0 and 2 in one cycle, then a hit and a miss together → `score` 2 then 3; `combo` 2 then 0; `max_combo` 2.
- Last entry launched → DRAIN; `slot_busy` drops to 0 → DONE; keycode_second=0x01 → IDLE, `score` held.
- Restart key mid-PLAY → one `clear_all` pulse and IDLE next cycle. `Reset_n` low mid-PLAY → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rhythm_pkg.sv
// rhythm_pkg
// Shared definitions for the arrow-drop chart sequencer:
//   state_e      - sequencer FSM states (encoding is what game_state reports)
//   KEY_START    - USB keycode that starts a song (space bar)
//   KEY_RESTART  - USB keycode that aborts / restarts a song
//   lane_t       - lane index type (four lanes)
package rhythm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [7:0] KEY_START   = 8'h2C;
  localparam logic [7:0] KEY_RESTART = 8'h01;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/note_scheduler_slot_alloc.sv
// slot_alloc
// Purely combinational helper for the dropper pool.
// Ports:
//   busy_i        - per-slot busy flags from the droppers
//   hit_i         - per-slot hit pulses
//   free_onehot_o - one-hot of the lowest-index free slot (0 when none free)
//   any_free_o    - at least one slot is free
//   hit_count_o   - number of hit pulses this cycle
module slot_alloc #(
  parameter int NUM_SLOTS = 8,
  localparam int CNT_W = $clog2(NUM_SLOTS + 1)
) (
  input  logic [NUM_SLOTS-1:0] busy_i,
  input  logic [NUM_SLOTS-1:0] hit_i,
  output logic [NUM_SLOTS-1:0] free_onehot_o,
  output logic                 any_free_o,
  output logic [CNT_W-1:0]     hit_count_o
);

  logic [NUM_SLOTS-1:0] freeMask;

  // Isolating the lowest set bit of the free mask (x & -x) gives the
  // lowest-index free slot without a priority chain.
  assign freeMask      = ~busy_i;
  assign free_onehot_o = freeMask & (~freeMask + NUM_SLOTS'(1));
  assign any_free_o    = |freeMask;

  // Population count of the hit pulses.
  always_comb begin
    hit_count_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_count_o = hit_count_o + CNT_W'(hit_i[i]);
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler
// Chart sequencer for the arrow-drop game. Walks the chart ROM, launches each
// note into the lowest free dropper slot once its launch frame is reached,
// and keeps score / combo / best combo from the droppers' hit and miss pulses.
// Ports:
//   frame_clk, Reset_n         - frame clock, async active-low reset
//   keycode, keycode_second    - USB keycodes (start / restart keys)
//   chart_addr                 - registered chart ROM address
//   chart_time/lane/last       - ROM data, valid one cycle after chart_addr
//   slot_busy/hit/miss         - dropper pool status
//   launch, launch_lane        - one-hot launch pulse and its lane
//   clear_all                  - one-cycle pulse returning all slots to idle
//   song_frame                 - frames elapsed since PLAY began
//   score, combo, max_combo    - saturating scoring outputs
//   game_state                 - encoded FSM state
module note_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int LANE_W    = 2,
  parameter int ADDR_W    = 6,
  parameter int TIME_W    = 12
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic [7:0]           keycode,
  input  logic [7:0]           keycode_second,
  output logic [ADDR_W-1:0]    chart_addr,
  input  logic [TIME_W-1:0]    chart_time,
  input  logic [LANE_W-1:0]    chart_lane,
  input  logic                 chart_last,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic [NUM_SLOTS-1:0] slot_hit,
  input  logic [NUM_SLOTS-1:0] slot_miss,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [LANE_W-1:0]    launch_lane,
  output logic                 clear_all,
  output logic [TIME_W-1:0]    song_frame,
  output logic [15:0]          score,
  output logic [7:0]           combo,
  output logic [7:0]           max_combo,
  output logic [2:0]           game_state
);

  import rhythm_pkg::*;

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  state_e                state_q,      state_d;
  logic [ADDR_W-1:0]     chartAddr_q,  chartAddr_d;
  logic [NUM_SLOTS-1:0]  launch_q,     launch_d;
  logic [LANE_W-1:0]     launchLane_q, launchLane_d;
  logic                  clearAll_q,   clearAll_d;
  logic [TIME_W-1:0]     songFrame_q,  songFrame_d;
  logic [15:0]           score_q,      score_d;
  logic [7:0]            combo_q,      combo_d;
  logic [7:0]            maxCombo_q,   maxCombo_d;

  logic [NUM_SLOTS-1:0]  freeOneHot;
  logic                  anyFree;
  logic [CNT_W-1:0]      hitCount;

  logic                  startKey;
  logic                  restartKey;
  logic                  entryDue;
  logic [TIME_W-1:0]     frameInc;

  logic [16:0]           scoreSum;
  logic [8:0]            comboSum;
  logic [15:0]           scoreNext;
  logic [7:0]            comboNext;
  logic [7:0]            maxNext;

  slot_alloc #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_slot_alloc (
    .busy_i       (slot_busy),
    .hit_i        (slot_hit),
    .free_onehot_o(freeOneHot),
    .any_free_o   (anyFree),
    .hit_count_o  (hitCount)
  );

  assign startKey   = (keycode == KEY_START)   || (keycode_second == KEY_START);
  assign restartKey = (keycode == KEY_RESTART) || (keycode_second == KEY_RESTART);
  assign entryDue   = (songFrame_q >= chart_time);
  assign frameInc   = (&songFrame_q) ? songFrame_q : songFrame_q + TIME_W'(1);

  // Candidate scoring update for this cycle. A miss anywhere breaks the
  // combo even if other slots hit in the same cycle; max_combo tracks the
  // post-update combo value.
  always_comb begin
    scoreSum  = {1'b0, score_q} + 17'(hitCount);
    comboSum  = {1'b0, combo_q} + 9'(hitCount);
    scoreNext = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
    if (|slot_miss) begin
      comboNext = 8'd0;
    end else begin
      comboNext = comboSum[8] ? 8'hFF : comboSum[7:0];
    end
    maxNext = (comboNext > maxCombo_q) ? comboNext : maxCombo_q;
  end

  // Next-state logic. Restart has priority over everything else in the
  // active states; any move into IDLE also zeroes address, frame and combo
  // so IDLE presents clean values from its first cycle.
  always_comb begin
    state_d      = state_q;
    chartAddr_d  = chartAddr_q;
    launch_d     = '0;
    launchLane_d = launchLane_q;
    clearAll_d   = 1'b0;
    songFrame_d  = songFrame_q;
    score_d      = score_q;
    combo_d      = combo_q;
    maxCombo_d   = maxCombo_q;

    if (state_q != ST_IDLE) begin
      score_d    = scoreNext;
      combo_d    = comboNext;
      maxCombo_d = maxNext;
    end

    case (state_q)
      ST_IDLE: begin
        if (startKey && !restartKey) begin
          state_d    = ST_LOAD;
          score_d    = '0;
          maxCombo_d = '0;
        end
      end
      ST_LOAD: begin
        if (restartKey) begin
          state_d    = ST_IDLE;
          clearAll_d = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_FETCH: begin
        songFrame_d = frameInc;
        if (restartKey) begin
          state_d    = ST_IDLE;
          clearAll_d = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        songFrame_d = frameInc;
        if (restartKey) begin
          state_d    = ST_IDLE;
          clearAll_d = 1'b1;
        end else if (entryDue && anyFree) begin
          launch_d     = freeOneHot;
          launchLane_d = chart_lane;
          if (chart_last) begin
            state_d = ST_DRAIN;
          end else begin
            chartAddr_d = chartAddr_q + ADDR_W'(1);
            state_d     = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        songFrame_d = frameInc;
        if (restartKey) begin
          state_d    = ST_IDLE;
          clearAll_d = 1'b1;
        end else if (slot_busy == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (restartKey) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) begin
      chartAddr_d = '0;
      songFrame_d = '0;
      combo_d     = '0;
    end
  end

  // State and output registers; the droppers share Reset_n, so reset
  // needs no clear_all pulse.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      chartAddr_q  <= '0;
      launch_q     <= '0;
      launchLane_q <= '0;
      clearAll_q   <= 1'b0;
      songFrame_q  <= '0;
      score_q      <= '0;
      combo_q      <= '0;
      maxCombo_q   <= '0;
    end else begin
      state_q      <= state_d;
      chartAddr_q  <= chartAddr_d;
      launch_q     <= launch_d;
      launchLane_q <= launchLane_d;
      clearAll_q   <= clearAll_d;
      songFrame_q  <= songFrame_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      maxCombo_q   <= maxCombo_d;
    end
  end

  assign chart_addr  = chartAddr_q;
  assign launch      = launch_q;
  assign launch_lane = launchLane_q;
  assign clear_all   = clearAll_q;
  assign song_frame  = songFrame_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = maxCombo_q;
  assign game_state  = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler
// Self-checking bench for note_scheduler. A synchronous chart ROM and a
// simple dropper-pool busy model surround the DUT. Expected launches are
// queued when each song's chart is loaded; a monitor pops one entry every
// time the DUT shows a launch pulse.
module tb_note_scheduler;

  import rhythm_pkg::*;

  typedef struct packed {
    logic [7:0]  oneHot;
    logic [1:0]  lane;
    logic [11:0] frame;
  } launch_t;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  keycode;
  logic [7:0]  keycode_second;
  logic [5:0]  chart_addr;
  logic [11:0] chart_time;
  lane_t       chart_lane;
  logic        chart_last;
  logic [7:0]  slot_busy;
  logic [7:0]  slot_hit;
  logic [7:0]  slot_miss;
  logic [7:0]  launch;
  logic [1:0]  launch_lane;
  logic        clear_all;
  logic [11:0] song_frame;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [2:0]  game_state;

  logic [11:0] romTime [64];
  lane_t       romLane [64];
  logic        romLast [64];

  logic [7:0]  busyModel = '0;
  logic [7:0]  setMask   = '0;
  logic [7:0]  freeMask  = '0;

  launch_t     expQ [$];
  int          vectors     = 0;
  int          miscompares = 0;

  note_scheduler #(
    .NUM_SLOTS(8), .LANE_W(2), .ADDR_W(6), .TIME_W(12)
  ) dut (
    .frame_clk     (clk),
    .Reset_n       (Reset_n),
    .keycode       (keycode),
    .keycode_second(keycode_second),
    .chart_addr    (chart_addr),
    .chart_time    (chart_time),
    .chart_lane    (chart_lane),
    .chart_last    (chart_last),
    .slot_busy     (slot_busy),
    .slot_hit      (slot_hit),
    .slot_miss     (slot_miss),
    .launch        (launch),
    .launch_lane   (launch_lane),
    .clear_all     (clear_all),
    .song_frame    (song_frame),
    .score         (score),
    .combo         (combo),
    .max_combo     (max_combo),
    .game_state    (game_state)
  );

  always #5 clk = ~clk;

  // Chart ROM with one cycle of read latency.
  always @(posedge clk) begin
    chart_time <= romTime[chart_addr];
    chart_lane <= romLane[chart_addr];
    chart_last <= romLast[chart_addr];
  end

  // Dropper pool: a launched slot turns busy, clear_all frees everything,
  // and the stimulus can force or release slots through the masks.
  always @(posedge clk) begin
    if (clear_all) busyModel <= '0;
    else           busyModel <= ((busyModel | launch) & ~freeMask) | setMask;
  end
  assign slot_busy = busyModel;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every launch pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (launch !== 8'h00) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_launch: got launch 0x%0h at frame %0d, expected none", launch, song_frame);
      end else begin
        launch_t e;
        e = expQ.pop_front();
        checkOutput("launch_onehot", 32'(launch), 32'(e.oneHot));
        checkOutput("launch_lane",   32'(launch_lane), 32'(e.lane));
        checkOutput("launch_frame",  32'(song_frame), 32'(e.frame));
      end
    end
  end

  task automatic clearRom();
    for (int i = 0; i < 64; i++) begin
      romTime[i] = 12'hFFF;
      romLane[i] = 2'd0;
      romLast[i] = 1'b1;
    end
  endtask

  task automatic setEntry(input int a, input logic [11:0] t, input lane_t l, input logic last);
    romTime[a] = t;
    romLane[a] = l;
    romLast[a] = last;
  endtask

  task automatic pushLaunch(input logic [7:0] oh, input lane_t l, input logic [11:0] f);
    launch_t e;
    e.oneHot = oh;
    e.lane   = l;
    e.frame  = f;
    expQ.push_back(e);
  endtask

  task automatic waitFrame(input logic [11:0] n);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (song_frame == n) found = 1'b1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_frame: song_frame never reached %0d, last value %0d", n, song_frame);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] k1, input logic [7:0] k2);
    keycode        = k1;
    keycode_second = k2;
    @(negedge clk);
    keycode        = 8'h00;
    keycode_second = 8'h00;
  endtask

  initial begin
    Reset_n        = 1'b0;
    keycode        = 8'h00;
    keycode_second = 8'h00;
    slot_hit       = 8'h00;
    slot_miss      = 8'h00;
    clearRom();
    repeat (3) @(negedge clk);

    checkOutput("reset_state",  32'(game_state), 32'(ST_IDLE));
    checkOutput("reset_addr",   32'(chart_addr), 0);
    checkOutput("reset_launch", {22'd0, launch, launch_lane}, 0);
    checkOutput("reset_clear",  32'(clear_all), 0);
    checkOutput("reset_frame",  32'(song_frame), 0);
    checkOutput("reset_score",  {score, combo, max_combo}, 0);
    Reset_n = 1'b1;
    @(negedge clk);

    // Song 1: two launches with a FETCH gap, a pending launch with the
    // pool full, then scoring during DRAIN.
    clearRom();
    setEntry(0, 12'd5,  2'd1, 1'b0);
    setEntry(1, 12'd5,  2'd3, 1'b0);
    setEntry(2, 12'd12, 2'd2, 1'b1);
    pushLaunch(8'b0000_0001, 2'd1, 12'd6);
    pushLaunch(8'b0000_0010, 2'd3, 12'd8);
    pushLaunch(8'b0100_0000, 2'd2, 12'd21);
    @(negedge clk);
    applyStimulus(KEY_START, 8'h00);
    checkOutput("s1_load", 32'(game_state), 32'(ST_LOAD));
    @(negedge clk);
    checkOutput("s1_play", 32'(game_state), 32'(ST_PLAY));
    checkOutput("s1_frame0", 32'(song_frame), 0);

    waitFrame(12'd9);
    setMask = 8'hFF;
    @(negedge clk);
    setMask = 8'h00;
    waitFrame(12'd15);
    checkOutput("s1_pending_play", 32'(game_state), 32'(ST_PLAY));
    checkOutput("s1_pending_addr", 32'(chart_addr), 2);
    waitFrame(12'd19);
    freeMask = 8'h40;
    @(negedge clk);
    freeMask = 8'h00;
    waitFrame(12'd22);
    checkOutput("s1_drain", 32'(game_state), 32'(ST_DRAIN));

    slot_hit = 8'b0000_0101;
    @(negedge clk);
    checkOutput("s1_score2", 32'(score), 2);
    checkOutput("s1_combo2", 32'(combo), 2);
    checkOutput("s1_max2",   32'(max_combo), 2);
    slot_hit  = 8'b0000_0010;
    slot_miss = 8'b0100_0000;
    @(negedge clk);
    slot_hit  = 8'h00;
    slot_miss = 8'h00;
    checkOutput("s1_score3", 32'(score), 3);
    checkOutput("s1_combo0", 32'(combo), 0);
    checkOutput("s1_max_hold", 32'(max_combo), 2);

    freeMask = 8'hFF;
    @(negedge clk);
    freeMask = 8'h00;
    @(negedge clk);
    checkOutput("s1_done", 32'(game_state), 32'(ST_DONE));
    @(negedge clk);
    checkOutput("s1_done_frame_hold", 32'(song_frame), 26);
    applyStimulus(8'h00, KEY_RESTART);
    checkOutput("s1_idle", 32'(game_state), 32'(ST_IDLE));
    checkOutput("s1_idle_score", {score, max_combo}, {16'd3, 8'd2});
    checkOutput("s1_idle_frame", {chart_addr, song_frame, combo}, 0);

    // Start and restart together: restart wins, nothing starts.
    applyStimulus(KEY_START, KEY_RESTART);
    checkOutput("start_restart_same", 32'(game_state), 32'(ST_IDLE));

    // Song 2: equal launch times, then abort mid-PLAY.
    clearRom();
    setEntry(0, 12'd3,  2'd0, 1'b0);
    setEntry(1, 12'd3,  2'd2, 1'b0);
    setEntry(2, 12'd60, 2'd1, 1'b1);
    pushLaunch(8'b0000_0001, 2'd0, 12'd4);
    pushLaunch(8'b0000_0010, 2'd2, 12'd6);
    @(negedge clk);
    applyStimulus(8'h00, KEY_START);
    checkOutput("s2_load", 32'(game_state), 32'(ST_LOAD));
    checkOutput("s2_load_clear", {score, max_combo}, 0);
    waitFrame(12'd10);
    applyStimulus(KEY_RESTART, 8'h00);
    checkOutput("s2_abort_idle", 32'(game_state), 32'(ST_IDLE));
    checkOutput("s2_abort_clear", 32'(clear_all), 1);
    checkOutput("s2_abort_zero", {chart_addr, song_frame}, 0);
    @(negedge clk);
    checkOutput("s2_clear_once", 32'(clear_all), 0);

    // Song 3: asynchronous reset mid-PLAY.
    clearRom();
    setEntry(0, 12'd2,  2'd3, 1'b0);
    setEntry(1, 12'd50, 2'd0, 1'b1);
    pushLaunch(8'b0000_0001, 2'd3, 12'd3);
    @(negedge clk);
    applyStimulus(KEY_START, 8'h00);
    waitFrame(12'd4);
    slot_hit = 8'b1000_0000;
    @(negedge clk);
    slot_hit = 8'h00;
    checkOutput("s3_score1", {score, combo}, {16'd1, 8'd1});
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("s3_async_state", 32'(game_state), 32'(ST_IDLE));
    checkOutput("s3_async_lane",  {22'd0, launch, launch_lane}, 0);
    checkOutput("s3_async_score", {score, combo, max_combo}, 0);
    checkOutput("s3_async_frame", {chart_addr, song_frame}, 0);
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("queue_empty", 32'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
